// File: rtl/jesd_tx_link_if.sv
// Link-side bundle between the sample TX adapter, the receiver SYNC~ line
// and the 8b/10b encoder lane for the JESD204B transmit link layer.
interface jesd_tx_link_if #(
    parameter int P = 32
);
    logic             tx_rst_n;
    logic             tx_en;
    logic             sync_n;
    logic             cgs_done;
    logic             ilas_done;
    logic             link_up;
    logic             tx_val;
    logic             tx_rdy;
    logic [P-1:0]     tx_dat;
    logic [P-1:0]     lane_dat;
    logic [P/8-1:0]   lane_k;

    // Upstream view: adapter/receiver drive control and payload, observe lane.
    modport master (
        output tx_rst_n, tx_en, sync_n, tx_val, tx_dat,
        input  cgs_done, ilas_done, link_up, tx_rdy, lane_dat, lane_k
    );

    // Link layer view.
    modport slave (
        input  tx_rst_n, tx_en, sync_n, tx_val, tx_dat,
        output cgs_done, ilas_done, link_up, tx_rdy, lane_dat, lane_k
    );
endinterface

// File: rtl/jesd_tx_link.sv
// Simplified single-lane JESD204B transmit link layer: CGS -> ILAS -> DATA
// bring-up, LMFC tracking, SYNC~ driven resync, registered lane output with
// per-octet K-character flags.
module jesd_tx_link #(
    parameter int P          = 32,
    parameter int F          = 2,
    parameter int K          = 16,
    parameter int ILAS_MF    = 4,
    parameter int RESYNC_CYC = 4
) (
    input  logic          clk,
    input  logic          rst,
    jesd_tx_link_if.slave lnk
);
    localparam int NOCT   = P / 8;
    localparam int MF_CYC = K * F * 8 / P;
    localparam int LMFC_W = (MF_CYC > 1) ? $clog2(MF_CYC) : 1;
    localparam int MF_W   = $clog2(ILAS_MF);
    localparam int LOW_W  = $clog2(RESYNC_CYC + 1);

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_CGS   = 2'd1,
        ST_ILAS  = 2'd2,
        ST_DATA  = 2'd3
    } state_t;

    state_t             state_reg, state_next;
    logic               sync_meta_reg, sync_s_reg;
    logic [LMFC_W-1:0]  lmfc_reg, lmfc_next;
    logic [MF_W-1:0]    mf_reg, mf_next;
    logic [LOW_W-1:0]   low_reg, low_next;
    logic               cgs_done_reg, cgs_done_next;
    logic               ilas_done_reg, ilas_done_next;
    logic               link_up_reg, link_up_next;
    logic [P-1:0]       lane_dat_reg, lane_dat_next;
    logic [NOCT-1:0]    lane_k_reg, lane_k_next;

    logic [P-1:0]       ilas_dat;
    logic [NOCT-1:0]    ilas_k;
    logic               lmfc_last, mf_last, mf_is_one, in_link, resync, link_ok;

    assign lmfc_last = (lmfc_reg == LMFC_W'(MF_CYC - 1));
    assign mf_last   = (mf_reg == MF_W'(ILAS_MF - 1));
    assign mf_is_one = (mf_reg == MF_W'(1));
    assign in_link   = (state_reg == ST_ILAS) || (state_reg == ST_DATA);
    // Fires on the RESYNC_CYC-th consecutive low cycle of the synchronised SYNC~.
    assign resync    = in_link && !sync_s_reg && (low_reg == LOW_W'(RESYNC_CYC - 1));
    assign link_ok   = lnk.tx_rst_n && lnk.tx_en;

    // ILAS octet content: position j within the multiframe selects the
    // /R/ start, /A/ end, /Q/ marker in the second multiframe, else j itself.
    generate
        for (genvar gi = 0; gi < NOCT; gi++) begin : g_ilas
            logic [15:0] j;
            logic        is_r, is_a, is_q;
            assign j    = 16'(lmfc_reg) * 16'(NOCT) + 16'(gi);
            assign is_r = (j == 16'd0);
            assign is_a = (j == 16'(K * F - 1));
            assign is_q = mf_is_one && (j == 16'd1);
            assign ilas_dat[gi*8 +: 8] = is_r ? 8'h1C :
                                         is_a ? 8'h7C :
                                         is_q ? 8'h9C : j[7:0];
            assign ilas_k[gi] = is_r || is_a || is_q;
        end
    endgenerate

    // Two-flop synchroniser for the asynchronous SYNC~ input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta_reg <= 1'b0;
            sync_s_reg    <= 1'b0;
        end else begin
            sync_meta_reg <= lnk.sync_n;
            sync_s_reg    <= sync_meta_reg;
        end
    end

    // Next-state logic; losing tx_rst_n/tx_en overrides everything.
    always_comb begin
        state_next = state_reg;
        if (!link_ok) begin
            state_next = ST_RESET;
        end else begin
            case (state_reg)
                ST_RESET: state_next = ST_CGS;
                ST_CGS:   if (sync_s_reg && lmfc_last) state_next = ST_ILAS;
                ST_ILAS: begin
                    if (resync)                    state_next = ST_CGS;
                    else if (lmfc_last && mf_last) state_next = ST_DATA;
                end
                ST_DATA:  if (resync) state_next = ST_CGS;
                default:  state_next = ST_RESET;
            endcase
        end
    end

    // LMFC, ILAS multiframe and SYNC~-low run counters.
    always_comb begin
        lmfc_next = lmfc_last ? '0 : lmfc_reg + LMFC_W'(1);
        if (state_reg == ST_RESET || state_next == ST_RESET)
            lmfc_next = '0;

        mf_next = mf_reg;
        if (state_reg != ST_ILAS)
            mf_next = '0;
        else if (lmfc_last)
            mf_next = mf_last ? '0 : mf_reg + MF_W'(1);

        low_next = '0;
        if (in_link && !sync_s_reg && !resync)
            low_next = low_reg + LOW_W'(1);
    end

    // Sticky status flags: set on the bring-up transitions, cleared only by
    // reset/disable or a resync.
    always_comb begin
        cgs_done_next  = cgs_done_reg;
        ilas_done_next = ilas_done_reg;
        link_up_next   = link_up_reg;
        if (state_next == ST_RESET || resync) begin
            cgs_done_next  = 1'b0;
            ilas_done_next = 1'b0;
            link_up_next   = 1'b0;
        end else begin
            if (state_reg == ST_CGS && state_next == ST_ILAS)
                cgs_done_next = 1'b1;
            if (state_reg == ST_ILAS && state_next == ST_DATA) begin
                ilas_done_next = 1'b1;
                link_up_next   = 1'b1;
            end
        end
    end

    // Lane word for the current state; an abort blanks it on the same edge.
    always_comb begin
        lane_dat_next = '0;
        lane_k_next   = '0;
        if (state_next != ST_RESET) begin
            case (state_reg)
                ST_CGS: begin
                    lane_dat_next = {NOCT{8'hBC}};
                    lane_k_next   = '1;
                end
                ST_ILAS: begin
                    lane_dat_next = ilas_dat;
                    lane_k_next   = ilas_k;
                end
                ST_DATA: if (lnk.tx_val) lane_dat_next = lnk.tx_dat;
                default: ;
            endcase
        end
    end

    // State, counters, status and lane registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_RESET;
            lmfc_reg      <= '0;
            mf_reg        <= '0;
            low_reg       <= '0;
            cgs_done_reg  <= 1'b0;
            ilas_done_reg <= 1'b0;
            link_up_reg   <= 1'b0;
            lane_dat_reg  <= '0;
            lane_k_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            lmfc_reg      <= lmfc_next;
            mf_reg        <= mf_next;
            low_reg       <= low_next;
            cgs_done_reg  <= cgs_done_next;
            ilas_done_reg <= ilas_done_next;
            link_up_reg   <= link_up_next;
            lane_dat_reg  <= lane_dat_next;
            lane_k_reg    <= lane_k_next;
        end
    end

    assign lnk.tx_rdy    = (state_reg == ST_DATA);
    assign lnk.cgs_done  = cgs_done_reg;
    assign lnk.ilas_done = ilas_done_reg;
    assign lnk.link_up   = link_up_reg;
    assign lnk.lane_dat  = lane_dat_reg;
    assign lnk.lane_k    = lane_k_reg;
endmodule

// File: tb/tb_jesd_tx_link.sv
// Bench for jesd_tx_link: a cycle-level behavioural model of the link
// bring-up checked every cycle, plus literal expectations at key points.
module tb_jesd_tx_link;
    localparam int P          = 32;
    localparam int F          = 2;
    localparam int K          = 16;
    localparam int ILAS_MF    = 4;
    localparam int RESYNC_CYC = 4;
    localparam int NOCT       = P / 8;
    localparam int MF_CYC     = K * F * 8 / P;
    localparam int ILAS_CYC   = ILAS_MF * MF_CYC;

    localparam int PH_RESET = 0;
    localparam int PH_CGS   = 1;
    localparam int PH_ILAS  = 2;
    localparam int PH_DATA  = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    jesd_tx_link_if #(.P(P)) lnk ();

    jesd_tx_link #(
        .P(P), .F(F), .K(K), .ILAS_MF(ILAS_MF), .RESYNC_CYC(RESYNC_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .lnk(lnk)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model state: phase, cycles since leaving reset (LMFC
    // alignment), cycles into ILAS, SYNC~ low run, synchroniser pipeline.
    int          ph = PH_RESET;
    int          t = 0;
    int          ilas_t = 0;
    int          low = 0;
    bit          s1 = 0, s2 = 0;
    logic [31:0] m_lane = '0;
    logic [3:0]  m_k = '0;
    bit          m_cgs = 0, m_ilas = 0, m_up = 0;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                ph = PH_RESET; t = 0; ilas_t = 0; low = 0; s1 = 0; s2 = 0;
                m_lane = '0; m_k = '0; m_cgs = 0; m_ilas = 0; m_up = 0;
            end else begin : step
                bit sync_cur;
                sync_cur = s2;
                m_lane = '0;
                m_k    = '0;
                if (ph == PH_CGS) begin
                    m_lane = 32'hBCBCBCBC;
                    m_k    = 4'hF;
                end else if (ph == PH_ILAS) begin
                    for (int i = 0; i < NOCT; i++) begin
                        int j, mfi;
                        j   = (ilas_t % MF_CYC) * NOCT + i;
                        mfi = ilas_t / MF_CYC;
                        if (j == 0) begin
                            m_lane[i*8 +: 8] = 8'h1C; m_k[i] = 1'b1;
                        end else if (j == K * F - 1) begin
                            m_lane[i*8 +: 8] = 8'h7C; m_k[i] = 1'b1;
                        end else if (mfi == 1 && j == 1) begin
                            m_lane[i*8 +: 8] = 8'h9C; m_k[i] = 1'b1;
                        end else begin
                            m_lane[i*8 +: 8] = j[7:0];
                        end
                    end
                end else if (ph == PH_DATA && lnk.tx_val) begin
                    m_lane = lnk.tx_dat;
                end

                if (!lnk.tx_rst_n || !lnk.tx_en) begin
                    m_lane = '0; m_k = '0;
                    m_cgs = 0; m_ilas = 0; m_up = 0;
                    ph = PH_RESET; t = 0; low = 0;
                end else if (ph == PH_RESET) begin
                    ph = PH_CGS; t = 0;
                end else if (ph == PH_CGS) begin
                    if (sync_cur && (t % MF_CYC) == MF_CYC - 1) begin
                        ph = PH_ILAS; ilas_t = 0; low = 0; m_cgs = 1;
                    end
                    t++;
                end else begin
                    low = sync_cur ? 0 : low + 1;
                    if (low == RESYNC_CYC) begin
                        ph = PH_CGS; low = 0;
                        m_cgs = 0; m_ilas = 0; m_up = 0;
                    end else if (ph == PH_ILAS) begin
                        if (ilas_t == ILAS_CYC - 1) begin
                            ph = PH_DATA; m_ilas = 1; m_up = 1;
                        end else begin
                            ilas_t++;
                        end
                    end
                    t++;
                end
                s2 = s1;
                s1 = lnk.sync_n;
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("lane_dat",  lnk.lane_dat,         m_lane);
            chk("lane_k",    32'(lnk.lane_k),      32'(m_k));
            chk("cgs_done",  32'(lnk.cgs_done),    32'(m_cgs));
            chk("ilas_done", 32'(lnk.ilas_done),   32'(m_ilas));
            chk("link_up",   32'(lnk.link_up),     32'(m_up));
            chk("tx_rdy",    32'(lnk.tx_rdy),      32'(ph == PH_DATA));
        end
    end

    initial begin
        rst          = 1'b1;
        lnk.tx_rst_n = 1'b1;
        lnk.tx_en    = 1'b1;
        lnk.sync_n   = 1'b0;
        lnk.tx_val   = 1'b0;
        lnk.tx_dat   = '0;
        repeat (3) @(negedge clk);
        chk("pin_reset_lane", lnk.lane_dat, 32'h0);
        chk("pin_reset_rdy", 32'(lnk.tx_rdy), 32'h0);
        rst = 1'b0;

        // CGS with SYNC~ held low
        repeat (22) @(negedge clk);
        chk("pin_cgs_lane", lnk.lane_dat, 32'hBCBCBCBC);
        chk("pin_cgs_k", 32'(lnk.lane_k), 32'hF);
        chk("pin_cgs_status", {29'd0, lnk.cgs_done, lnk.ilas_done, lnk.link_up}, 32'h0);

        // Release SYNC~; payload offered during ILAS must be ignored
        lnk.sync_n = 1'b1;
        lnk.tx_val = 1'b1;
        lnk.tx_dat = 32'h12345678;
        for (int c = 0; c < 40 && !lnk.cgs_done; c++) @(negedge clk);
        chk("wait_cgs_done", 32'(lnk.cgs_done), 32'h1);
        chk("pin_last_cgs", lnk.lane_dat, 32'hBCBCBCBC);
        @(negedge clk);
        chk("pin_ilas_w0", lnk.lane_dat, 32'h0302011C);
        chk("pin_ilas_w0_k", 32'(lnk.lane_k), 32'h1);
        repeat (7) @(negedge clk);
        chk("pin_ilas_w7", lnk.lane_dat, 32'h7C1E1D1C);
        chk("pin_ilas_w7_k", 32'(lnk.lane_k), 32'h8);
        @(negedge clk);
        chk("pin_ilas_mf1_w0", lnk.lane_dat, 32'h03029C1C);
        chk("pin_ilas_mf1_w0_k", 32'(lnk.lane_k), 32'h3);
        repeat (22) @(negedge clk);
        chk("pin_ilas_not_done_31", 32'(lnk.ilas_done), 32'h0);
        @(negedge clk);
        chk("pin_ilas_done_32", 32'(lnk.ilas_done), 32'h1);
        chk("pin_link_up_32", 32'(lnk.link_up), 32'h1);
        chk("pin_tx_rdy_data", 32'(lnk.tx_rdy), 32'h1);

        // Payload in DATA
        lnk.tx_dat = 32'hDEADBEEF;
        lnk.tx_val = 1'b1;
        @(negedge clk);
        chk("pin_data_beef", lnk.lane_dat, 32'hDEADBEEF);
        chk("pin_data_k", 32'(lnk.lane_k), 32'h0);
        lnk.tx_val = 1'b0;
        @(negedge clk);
        chk("pin_data_idle", lnk.lane_dat, 32'h0);

        // Short SYNC~ glitch (3 cycles) must not resync
        lnk.sync_n = 1'b0;
        repeat (3) @(negedge clk);
        lnk.sync_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("pin_glitch_link_up", 32'(lnk.link_up), 32'h1);

        // Sustained SYNC~ low forces resync to CGS
        lnk.sync_n = 1'b0;
        for (int c = 0; c < 12 && lnk.link_up; c++) @(negedge clk);
        chk("wait_resync", 32'(lnk.link_up), 32'h0);
        chk("pin_resync_rdy", 32'(lnk.tx_rdy), 32'h0);
        repeat (2) @(negedge clk);
        chk("pin_resync_cgs", lnk.lane_dat, 32'hBCBCBCBC);

        // Drop tx_en mid-ILAS
        lnk.sync_n = 1'b1;
        for (int c = 0; c < 40 && !lnk.cgs_done; c++) @(negedge clk);
        chk("wait_cgs_done_2", 32'(lnk.cgs_done), 32'h1);
        repeat (10) @(negedge clk);
        lnk.tx_en = 1'b0;
        @(negedge clk);
        chk("pin_abort_lane", lnk.lane_dat, 32'h0);
        chk("pin_abort_k", 32'(lnk.lane_k), 32'h0);
        chk("pin_abort_status", {29'd0, lnk.cgs_done, lnk.ilas_done, lnk.link_up}, 32'h0);
        lnk.tx_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("pin_reenable_cgs", lnk.lane_dat, 32'hBCBCBCBC);
        repeat (6) @(negedge clk);
        chk("pin_lmfc_restart_pre", 32'(lnk.cgs_done), 32'h0);
        @(negedge clk);
        chk("pin_lmfc_restart", 32'(lnk.cgs_done), 32'h1);
        for (int c = 0; c < 40 && !lnk.link_up; c++) @(negedge clk);
        chk("wait_link_up_2", 32'(lnk.link_up), 32'h1);

        // Asynchronous reset mid-DATA, observed before the next clock edge
        lnk.tx_val = 1'b1;
        lnk.tx_dat = 32'hA5A5A5A5;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("pin_arst_lane", lnk.lane_dat, 32'h0);
        chk("pin_arst_link_up", 32'(lnk.link_up), 32'h0);
        chk("pin_arst_rdy", 32'(lnk.tx_rdy), 32'h0);
        chk("pin_arst_cgs", 32'(lnk.cgs_done), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        lnk.tx_val = 1'b0;
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/jesd_tx_link.md
Name: jesd_tx_link

Overview:
- Simplified JESD204B transmit link layer for a single lane.
- Sits directly downstream of the sample TX adapter. It consumes that adapter's reset, enable and val/rdy/dat outputs, and produces the cgs_done, ilas_done and link_up status it gates on.
- Runs the link bring-up sequence (code group synchronisation, then initial lane alignment sequence, then data) and emits a lane word with per-octet K-character flags toward the 8b/10b encoder.

Parameters:
- P, 32, lane word width in bits; a multiple of 8, giving P/8 octets per cycle.
- F, 2, octets per frame.
- K, 16, frames per multiframe. K*F must be a multiple of P/8. MF_CYC = K*F*8/P cycles per multiframe.
- ILAS_MF, 4, multiframes in the ILAS; must be at least 2.
- RESYNC_CYC, 4, consecutive cycles of synchronised sync_n low that force a resync.

Ports:
- clk  in  1  single clock for all logic
- rst  in  1  asynchronous, active-high reset
- tx_rst_n  in  1  link soft reset from the TX adapter; low holds the link in RESET
- tx_en  in  1  link enable from the TX adapter
- sync_n  in  1  receiver SYNC~, asynchronous to clk; low requests synchronisation
- cgs_done  out  1  CGS complete
- ilas_done  out  1  ILAS complete
- link_up  out  1  link in DATA state
- tx_val  in  1  payload valid
- tx_rdy  out  1  payload ready
- tx_dat  in  P  payload word; octet 0 is bits [7:0] and is first in time
- lane_dat  out  P  lane octets
- lane_k  out  P/8  per-octet K-character flag

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high. While rst is high, every output is 0 and state = RESET.
- sync_n is passed through a 2-flop synchroniser (sync_s) before any use. Its reset value is 0.
- LMFC counter lmfc (0..MF_CYC-1):
  - Held at 0 in RESET.
  - Otherwise increments every cycle and wraps MF_CYC-1 -> 0.
  - A multiframe boundary is the cycle with lmfc == 0.
- State transitions are evaluated at each clk edge. If tx_rst_n == 0 or tx_en == 0, the next state is RESET from any state; this overrides every other transition.
- RESET:
  - lane_dat = 0, lane_k = 0, all status outputs = 0.
  - Goes to CGS the cycle after tx_rst_n && tx_en.
- CGS:
  - Every octet is K28.5 (0xBC, k=1).
  - When sync_s == 1 and lmfc == MF_CYC-1, goes to ILAS, so the ILAS starts on an LMFC boundary.
  - cgs_done is set on that transition.
- ILAS:
  - Runs ILAS_MF multiframes, tracked by counter mf = 0..ILAS_MF-1.
  - Octet index within the multiframe: j = lmfc*(P/8) + i.
  - j == 0 carries K28.0 (0x1C, k=1).
  - j == K*F-1 carries K28.3 (0x7C, k=1).
  - In mf == 1 only, j == 1 carries K28.4 (0x9C, k=1).
  - All other octets carry j[7:0] with k=0.
  - After the last octet of mf == ILAS_MF-1, goes to DATA; ilas_done is set.
- DATA:
  - link_up = 1. tx_rdy = 1, combinational from state.
  - On tx_val: lane_dat = tx_dat, lane_k = 0.
  - On !tx_val: lane_dat = 0, lane_k = 0.
- Latency: lane_dat and lane_k are registered, one cycle after state/lmfc/tx_dat.
- Resync:
  - In ILAS or DATA, sync_s == 0 for RESYNC_CYC consecutive cycles returns the block to CGS.
  - cgs_done, ilas_done and link_up clear on that edge; tx_rdy drops the same cycle as the state change.
  - Any return of sync_s to 1 restarts the low-count.
  - In CGS, sync_s == 0 is the normal condition.
- Status outputs: cgs_done, ilas_done and link_up are registered. They clear in RESET and on resync, and never clear otherwise.
- tx_rdy is 0 outside DATA. tx_val without tx_rdy is ignored and consumes no data.
- Reset mid-operation: rst or tx_rst_n low during ILAS or DATA aborts immediately. Any partial multiframe is dropped, and restart begins from CGS with lmfc = 0.

Test Plan (defaults: MF_CYC = 8, ILAS = 32 cycles):
- Reset release with tx_rst_n = 1, tx_en = 1 and sync_n held 0 for 20 cycles -> every lane word is 0xBCBCBCBC with lane_k = 4'hF; all status outputs stay 0.
- Raise sync_n -> after the 2-cycle synchroniser, ILAS starts at the next lmfc == 0 and cgs_done = 1. First ILAS word = 0x03_02_01_1C with lane_k = 4'b0001. Word 7 of each multiframe = 0x7C_1E_1D_1C with lane_k = 4'b1000. Word 0 of mf 1 = 0x03_02_9C_1C with lane_k = 4'b0011. ilas_done = 1 and link_up = 1 after exactly 32 ILAS cycles.
- In DATA, drive tx_dat = 0xDEADBEEF with tx_val = 1 -> lane_dat = 0xDEADBEEF and lane_k = 0 one cycle later. Drive tx_val = 0 -> lane_dat = 0.
- In DATA, pull sync_n low for 3 cycles -> no change. Pull it low for 4 cycles -> state returns to CGS, link_up = 0 and tx_rdy = 0, and lane words return to 0xBCBCBCBC.
- Drop tx_en mid-ILAS -> next cycle all outputs are 0 and state = RESET. Re-enable -> full CGS then ILAS sequence with lmfc restarted from 0.
- Assert rst asynchronously mid-DATA -> outputs go to 0 without waiting for a clock edge.
